// File: rtl/pipelined_addsub_pkg.sv
// Shared types, constants and helpers for the pipelined adder/subtractor.
// The mode encoding and the stage-valid reset value are used by the top level.
package pipelined_addsub_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam logic PIPE_STAGE_VALID_RESET = 1'b0;

  // Majority function: the carry out of one full-adder cell.
  function automatic logic fa_carry(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // A split is only legal if every carry chunk has the same width.
  function automatic bit legal_split(input int n, input int s);
    return (s >= 1) && (n >= s) && ((n % s) == 0);
  endfunction

endpackage

// File: rtl/pipelined_addsub_rca_chunk.sv
// Combinational W-bit ripple-carry chunk built from full-adder cells.
// c_msb_in exposes the carry into the top bit so the top level can derive signed overflow.
module rca_chunk
  import pipelined_addsub_pkg::*;
#(
  parameter int W = 25
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = fa_carry(a[i], b[i], c[i]);
    end
  end

  assign co       = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor: S ripple chunks, one register stage per chunk,
// with a single global stall enable driven by the output handshake.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int N = 100,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int W = N / S;

  if (!legal_split(N, S)) begin : g_bad_split
    $error("pipelined_addsub: N must be a non-zero multiple of S");
  end

  logic         stage_en;
  logic [N-1:0] b_eff;
  logic         c_eff;

  // Per-stage registers: index k holds the op after chunk k has been added.
  logic [S-1:0]        vld_q, vld_d;
  logic [S-1:0]        cy_q, cy_d;
  logic [S-1:0]        cm_q, cm_d;
  logic [S-1:0][N-1:0] a_q, a_d;
  logic [S-1:0][N-1:0] b_q, b_d;
  logic [S-1:0][N-1:0] sum_q, sum_d;

  logic [W-1:0] ch_a  [S];
  logic [W-1:0] ch_b  [S];
  logic [W-1:0] ch_s  [S];
  logic         ch_ci [S];
  logic         ch_co [S];
  logic         ch_cm [S];

  assign stage_en = ~vld_q[S-1] | out_ready;
  assign in_ready = stage_en;

  always_comb begin
    b_eff = b;
    c_eff = cin;
    if (mode == MODE_SUB) begin
      b_eff = ~b;
      c_eff = 1'b1;
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_chunk
    if (k == 0) begin : g_first
      assign ch_a[k]  = a[W-1:0];
      assign ch_b[k]  = b_eff[W-1:0];
      assign ch_ci[k] = c_eff;
    end else begin : g_rest
      assign ch_a[k]  = a_q[k-1][k*W +: W];
      assign ch_b[k]  = b_q[k-1][k*W +: W];
      assign ch_ci[k] = cy_q[k-1];
    end

    rca_chunk #(.W(W)) u_rca (
      .a        (ch_a[k]),
      .b        (ch_b[k]),
      .ci       (ch_ci[k]),
      .s        (ch_s[k]),
      .co       (ch_co[k]),
      .c_msb_in (ch_cm[k])
    );
  end

  // Bubbles shift through exactly like data; nothing moves unless the whole pipe can.
  always_comb begin
    vld_d = vld_q;
    cy_d  = cy_q;
    cm_d  = cm_q;
    a_d   = a_q;
    b_d   = b_q;
    sum_d = sum_q;
    if (stage_en) begin
      vld_d[0]         = in_valid;
      a_d[0]           = a;
      b_d[0]           = b_eff;
      sum_d[0]         = '0;
      sum_d[0][W-1:0]  = ch_s[0];
      cy_d[0]          = ch_co[0];
      cm_d[0]          = ch_cm[0];
      for (int k = 1; k < S; k++) begin
        vld_d[k]            = vld_q[k-1];
        a_d[k]              = a_q[k-1];
        b_d[k]              = b_q[k-1];
        sum_d[k]            = sum_q[k-1];
        sum_d[k][k*W +: W]  = ch_s[k];
        cy_d[k]             = ch_co[k];
        cm_d[k]             = ch_cm[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= {S{PIPE_STAGE_VALID_RESET}};
      cy_q  <= '0;
      cm_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      cm_q  <= cm_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
    end
  end

  assign out_valid = vld_q[S-1];
  assign sum       = sum_q[S-1];
  assign cout      = cy_q[S-1];
  assign ovf       = cm_q[S-1] ^ cy_q[S-1];

  // Operand copies in the last stage and the early carry-into-MSB bits are never consumed.
  logic unused_bits;
  assign unused_bits = ^{a_q[S-1], b_q[S-1], cm_q};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: three instances (16/4, 8/1, 12/3) driven in lockstep,
// a shadow valid-pipe model for handshake checks, and a directed vector table for the 16-bit instance.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready, cin, mode;
  logic [15:0] a, b;

  logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, of0, of1, of2;
  logic [15:0] s0;
  logic [7:0]  s1;
  logic [11:0] s2;

  pipelined_addsub #(.N(16), .S(4)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
    .cin(cin), .mode(mode), .out_valid(ov0), .out_ready(out_ready), .sum(s0),
    .cout(co0), .ovf(of0));

  pipelined_addsub #(.N(8), .S(1)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .a(a[7:0]), .b(b[7:0]),
    .cin(cin), .mode(mode), .out_valid(ov1), .out_ready(out_ready), .sum(s1),
    .cout(co1), .ovf(of1));

  pipelined_addsub #(.N(12), .S(3)) u_dut12 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2), .a(a[11:0]), .b(b[11:0]),
    .cin(cin), .mode(mode), .out_valid(ov2), .out_ready(out_ready), .sum(s2),
    .cout(co2), .ovf(of2));

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        mode;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  int   SS [3] = '{4, 1, 3};
  int   NW [3] = '{16, 8, 12};
  exp_t q0[$], q1[$], q2[$];
  logic [3:0] sv [3];
  logic ov_s [3];
  logic ir_s [3];
  logic held_v [3];
  exp_t held [3];
  int   pops [3];
  int   first [3];
  logic use_tab;
  exp_t tab_exp;
  vec_t tab [8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci, input logic md, input int n);
    logic [16:0] mask, ae, be, full;
    logic        ce;
    exp_t        r;
    mask   = (17'd1 << n) - 17'd1;
    ae     = {1'b0, av} & mask;
    be     = md ? ({1'b0, ~bv} & mask) : ({1'b0, bv} & mask);
    ce     = md ? 1'b1 : ci;
    full   = ae + be + {16'd0, ce};
    r.sum  = full[15:0] & mask[15:0];
    r.cout = full[n];
    r.ovf  = (ae[n-1] == be[n-1]) && (r.sum[n-1] != ae[n-1]);
    return r;
  endfunction

  function automatic logic get_ov(input int d);
    case (d)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic get_ir(input int d);
    case (d)
      0: return ir0;
      1: return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic exp_t get_out(input int d);
    exp_t r;
    case (d)
      0: begin r.sum = s0;          r.cout = co0; r.ovf = of0; end
      1: begin r.sum = {8'd0, s1};  r.cout = co1; r.ovf = of1; end
      default: begin r.sum = {4'd0, s2}; r.cout = co2; r.ovf = of2; end
    endcase
    return r;
  endfunction

  task automatic q_push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int d, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int q_size(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // One clock: sample at negedge+1, score transfers, advance the shadow valid pipes.
  task automatic step();
    exp_t g, e;
    bit   ok;
    logic ovd, ird, exp_ov;
    #1;
    for (int d = 0; d < 3; d++) begin
      ovd    = get_ov(d);
      ird    = get_ir(d);
      g      = get_out(d);
      ov_s[d] = ovd;
      ir_s[d] = ird;
      exp_ov = sv[d][SS[d]-1];
      chk($sformatf("out_valid d%0d", d), {31'd0, ovd}, {31'd0, exp_ov});
      chk($sformatf("in_ready d%0d", d), {31'd0, ird}, {31'd0, (!exp_ov || out_ready)});
      if (!reset) begin
        if (ovd && out_ready) begin
          q_pop(d, e, ok);
          pops[d]++;
          if (!ok) chk($sformatf("unexpected_output d%0d", d), 32'd1, 32'd0);
          else begin
            chk($sformatf("sum d%0d", d), {16'd0, g.sum}, {16'd0, e.sum});
            chk($sformatf("cout d%0d", d), {31'd0, g.cout}, {31'd0, e.cout});
            chk($sformatf("ovf d%0d", d), {31'd0, g.ovf}, {31'd0, e.ovf});
          end
        end
        if (ovd && !out_ready) begin
          if (held_v[d]) begin
            chk($sformatf("hold_sum d%0d", d), {16'd0, g.sum}, {16'd0, held[d].sum});
            chk($sformatf("hold_flags d%0d", d), {30'd0, g.cout, g.ovf},
                {30'd0, held[d].cout, held[d].ovf});
          end
          held[d]   = g;
          held_v[d] = 1'b1;
        end else begin
          held_v[d] = 1'b0;
        end
        if (in_valid && ird)
          q_push(d, (d == 0 && use_tab) ? tab_exp : model(a, b, cin, mode, NW[d]));
      end
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        sv[d]     = 4'd0;
        held_v[d] = 1'b0;
        case (d)
          0: q0.delete();
          1: q1.delete();
          default: q2.delete();
        endcase
      end else if (!sv[d][SS[d]-1] || out_ready) begin
        sv[d] = ((sv[d] << 1) | {3'd0, in_valid}) & 4'((1 << SS[d]) - 1);
      end
    end
    @(negedge clk);
  endtask

  // Issue the currently driven op into an empty pipe and measure when it emerges.
  task automatic issue_and_measure();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) first[d] = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      for (int d = 0; d < 3; d++)
        if (ov_s[d] && first[d] == 0) first[d] = i;
    end
    for (int d = 0; d < 3; d++)
      chk($sformatf("latency d%0d", d), first[d], SS[d]);
  endtask

  task automatic rand_ops();
    a    = 16'($urandom);
    b    = 16'($urandom);
    cin  = 1'($urandom);
    mode = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, cyc, stall_cnt;

    tab[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tab[1] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tab[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tab[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tab[4] = '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
    tab[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tab[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tab[7] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; mode = 1'b0; use_tab = 1'b0; tab_exp = '0;
    for (int d = 0; d < 3; d++) begin
      sv[d] = 4'd0; held_v[d] = 1'b0; held[d] = '0; pops[d] = 0; first[d] = 0;
      ov_s[d] = 1'b0; ir_s[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", {29'd0, ov0, ov1, ov2}, 32'd0);
    chk("reset sum16", {16'd0, s0}, 32'd0);
    chk("reset sum8_12", {12'd0, s1, s2}, 32'd0);
    chk("reset flags", {26'd0, co0, co1, co2, of0, of1, of2}, 32'd0);
    reset = 1'b0;

    // Directed table; the 16-bit instance is scored against the table constants.
    use_tab = 1'b1;
    for (int v = 0; v < 8; v++) begin
      a = tab[v].a; b = tab[v].b; cin = tab[v].cin; mode = tab[v].mode;
      tab_exp = '{sum: tab[v].sum, cout: tab[v].cout, ovf: tab[v].ovf};
      issue_and_measure();
    end
    use_tab = 1'b0;

    // Back-to-back stream with a 3-cycle consumer stall in the middle.
    pops[0] = 0; acc = 0; cyc = 0; stall_cnt = 0;
    rand_ops();
    in_valid = 1'b1;
    while (acc < 8 && cyc < 40) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      step();
      if (ir_s[0]) begin
        acc++;
        rand_ops();
      end else begin
        stall_cnt++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    chk("stream accepted", acc, 8);
    chk("stream results", pops[0], 8);
    chk("stream stall cycles", stall_cnt, 3);
    chk("stream queue empty", q_size(0), 0);

    // Reset with ops in flight, including one offered in the reset cycle itself.
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      rand_ops();
      step();
    end
    rand_ops();
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("midreset out_valid", {29'd0, ov0, ov1, ov2}, 32'd0);
    chk("midreset sum16", {16'd0, s0}, 32'd0);
    chk("midreset flags", {26'd0, co0, co1, co2, of0, of1, of2}, 32'd0);
    repeat (6) step();
    a = 16'h0F0F; b = 16'h0101; cin = 1'b1; mode = 1'b0;
    issue_and_measure();

    // Randomised traffic with random backpressure on all three instances.
    for (int i = 0; i < 300; i++) begin
      rand_ops();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    for (int d = 0; d < 3; d++)
      chk($sformatf("final queue empty d%0d", d), q_size(d), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
